writeback_stage: RTL and testbench

//  Writer end of the register-file write port: the W pipeline register plus

---
 rtl/writeback_stage_if.sv | 39 +++
 rtl/writeback_stage.sv | 96 +++++++++
 tb/tb_writeback_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: M-stage inputs, register-file write port, PC redirect, retire count and Decode read bypass
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              valid_m;
    logic              reg_write_m;
    logic              mem_to_reg_m;
    logic [ADDR_W-1:0] wa3_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] read_data_m;
    logic              stall_w;
    logic              flush_w;
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic              pc_src_w;
    logic [DATA_W-1:0] pc_target_w;
    logic [CNT_W-1:0]  retire_cnt;
    logic [ADDR_W-1:0] ra1_d;
    logic [ADDR_W-1:0] ra2_d;
    logic [DATA_W-1:0] rd1_rf;
    logic [DATA_W-1:0] rd2_rf;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    modport master (
        output valid_m, reg_write_m, mem_to_reg_m, wa3_m, alu_result_m, read_data_m,
        output stall_w, flush_w, ra1_d, ra2_d, rd1_rf, rd2_rf,
        input  we3, a3, wd3, pc_src_w, pc_target_w, retire_cnt, rd1_d, rd2_d
    );

    modport slave (
        input  valid_m, reg_write_m, mem_to_reg_m, wa3_m, alu_result_m, read_data_m,
        input  stall_w, flush_w, ra1_d, ra2_d, rd1_rf, rd2_rf,
        output we3, a3, wd3, pc_src_w, pc_target_w, retire_cnt, rd1_d, rd2_d
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: W pipeline register, result select, R15 redirect with branch-shadow squash, retire counter.
// Optional WB_BYPASS_EN: same-cycle write-through of wd3 onto the Decode read ports.
module writeback_stage #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 4,
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input logic               clk,
    input logic               rst_n,
    writeback_stage_if.slave  wb
);
    typedef enum logic {RUN, SHADOW} state_t;

    state_t            state;
    logic [2:0]        shadow_cnt;
    logic              valid_w;
    logic              done_w;
    logic              reg_write_w;
    logic              mem_to_reg_w;
    logic [ADDR_W-1:0] wa3_w;
    logic [DATA_W-1:0] alu_result_w;
    logic [DATA_W-1:0] read_data_w;
    logic [CNT_W-1:0]  retire_cnt;
    logic              fire;
    logic              is_r15;
    logic              we3;
    logic              pc_src;
    logic [DATA_W-1:0] result;

    assign fire   = valid_w & reg_write_w & ~done_w;
    assign is_r15 = wa3_w == '1;
    assign we3    = fire & ~is_r15;
    assign pc_src = fire & is_r15;
    assign result = mem_to_reg_w ? read_data_w : alu_result_w;

    assign wb.we3         = we3;
    assign wb.a3          = wa3_w;
    assign wb.wd3         = result;
    assign wb.pc_src_w    = pc_src;
    assign wb.pc_target_w = result;
    assign wb.retire_cnt  = retire_cnt;

    // W register and shadow FSM: flush beats stall beats load; a held instruction fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            shadow_cnt   <= '0;
            valid_w      <= 1'b0;
            done_w       <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            wa3_w        <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
        end else if (wb.flush_w) begin
            valid_w    <= 1'b0;
            done_w     <= 1'b0;
            state      <= RUN;
            shadow_cnt <= '0;
        end else if (wb.stall_w) begin
            done_w <= done_w | fire;
        end else begin
            valid_w      <= wb.valid_m & (state == RUN);
            done_w       <= 1'b0;
            reg_write_w  <= wb.reg_write_m;
            mem_to_reg_w <= wb.mem_to_reg_m;
            wa3_w        <= wb.wa3_m;
            alu_result_w <= wb.alu_result_m;
            read_data_w  <= wb.read_data_m;
            if (state == RUN) begin
                if (pc_src) begin
                    state      <= SHADOW;
                    shadow_cnt <= 3'(SHADOW_CYCLES);
                end
            end else begin
                shadow_cnt <= shadow_cnt - 3'd1;
                if (shadow_cnt == 3'd1) state <= RUN;
            end
        end
    end

    // Retire count: an instruction retires when it leaves W neither stalled nor flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt <= '0;
        else if (valid_w && !wb.stall_w && !wb.flush_w) retire_cnt <= retire_cnt + CNT_W'(1);
    end

`ifdef WB_BYPASS_EN
    assign wb.rd1_d = (we3 && wa3_w == wb.ra1_d) ? result : wb.rd1_rf;
    assign wb.rd2_d = (we3 && wa3_w == wb.ra2_d) ? result : wb.rd2_rf;
`else
    assign wb.rd1_d = wb.rd1_rf;
    assign wb.rd2_d = wb.rd2_rf;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven check of writeback_stage plus reset-in-shadow and counter-wrap sequences
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sm_valid = 1'b0;
    int   total = 0;
    int   bad = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback_stage_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(16)) wb ();
    writeback_stage_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(4))  sm ();

    writeback_stage #(.DATA_W(32), .ADDR_W(4), .SHADOW_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb)
    );
    writeback_stage #(.DATA_W(32), .ADDR_W(4), .SHADOW_CYCLES(2), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .wb(sm)
    );

    assign sm.valid_m      = sm_valid;
    assign sm.reg_write_m  = 1'b1;
    assign sm.mem_to_reg_m = 1'b0;
    assign sm.wa3_m        = 4'd1;
    assign sm.alu_result_m = 32'h1;
    assign sm.read_data_m  = 32'h0;
    assign sm.stall_w      = 1'b0;
    assign sm.flush_w      = 1'b0;
    assign sm.ra1_d        = 4'd0;
    assign sm.ra2_d        = 4'd0;
    assign sm.rd1_rf       = 32'h0;
    assign sm.rd2_rf       = 32'h0;

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, m2r;
        logic [3:0]  wa;
        logic [31:0] alu, rd;
        logic        st, fl;
        logic [3:0]  r1, r2;
        logic        ew, ep;
        logic [3:0]  ea;
        logic [31:0] ed;
        logic [15:0] er;
        logic        cd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic v, rw, m2r, input logic [3:0] wa, input logic [31:0] alu, rd,
                                input logic st, fl, input logic [3:0] r1, r2, input logic ew, ep,
                                input logic [3:0] ea, input logic [31:0] ed, input logic [15:0] er, input logic cd);
        vec_t t;
        t.v = v; t.rw = rw; t.m2r = m2r; t.wa = wa; t.alu = alu; t.rd = rd; t.st = st; t.fl = fl;
        t.r1 = r1; t.r2 = r2; t.ew = ew; t.ep = ep; t.ea = ea; t.ed = ed; t.er = er; t.cd = cd;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, rw, m2r, input logic [3:0] wa, input logic [31:0] alu, rd,
                         input logic st, fl, input logic [3:0] r1, r2);
        wb.valid_m = v; wb.reg_write_m = rw; wb.mem_to_reg_m = m2r; wb.wa3_m = wa;
        wb.alu_result_m = alu; wb.read_data_m = rd; wb.stall_w = st; wb.flush_w = fl;
        wb.ra1_d = r1; wb.ra2_d = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wb.rd1_rf = 32'h55;
        wb.rd2_rf = 32'h66;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 4'd3,  32'h1234, 32'h0, 1'b0, 1'b0, 4'd3,  4'd3, 1'b1, 1'b0, 4'd3,  32'h1234, 16'd0, 1'b1);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 4'd5,  32'h0, 32'hCAFE0001, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd5, 32'hCAFE0001, 16'd1, 1'b1);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 4'd6,  32'h77, 32'h0, 1'b1, 1'b0, 4'd5,  4'd0, 1'b0, 1'b0, 4'd5,  32'hCAFE0001, 16'd1, 1'b1);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 4'd7,  32'hAA,  32'h0, 1'b0, 1'b0, 4'd7,  4'd3, 1'b1, 1'b0, 4'd7,  32'hAA,   16'd2, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 4'd8,  32'h10,  32'h0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd2, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'h0,   32'h0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd2, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 4'd15, 32'h100, 32'h0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b0, 1'b1, 4'd15, 32'h100,  16'd2, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'h0,   32'h0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd3, 1'b1);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 4'd1,  32'h11,  32'h0, 1'b0, 1'b0, 4'd1,  4'd0, 1'b0, 1'b0, 4'd1,  32'h11,   16'd3, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'd2,  32'h22,  32'h0, 1'b0, 1'b0, 4'd2,  4'd0, 1'b0, 1'b0, 4'd2,  32'h22,   16'd3, 1'b1);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 4'd4,  32'h44,  32'h0, 1'b0, 1'b0, 4'd4,  4'd1, 1'b1, 1'b0, 4'd4,  32'h44,   16'd3, 1'b1);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 4'd5,  32'h55,  32'h0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd3, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 4'd9,  32'h99,  32'h0, 1'b0, 1'b0, 4'd9,  4'd0, 1'b0, 1'b0, 4'd9,  32'h99,   16'd3, 1'b1);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 4'd15, 32'h200, 32'h0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 4'd15, 32'h200,  16'd4, 1'b1);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 4'd6,  32'h66,  32'h0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd4, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 4'd6,  32'h66,  32'h0, 1'b0, 1'b0, 4'd6,  4'd6, 1'b1, 1'b0, 4'd6,  32'h66,   16'd4, 1'b1);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'h0,   32'h0, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 4'd0,  32'h0,    16'd5, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_we3", 0, 32'(wb.we3), 32'd0);
        check("rst_pc_src", 0, 32'(wb.pc_src_w), 32'd0);
        check("rst_a3", 0, 32'(wb.a3), 32'd0);
        check("rst_wd3", 0, wb.wd3, 32'd0);
        check("rst_retire", 0, 32'(wb.retire_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].wa, tbl[i].alu, tbl[i].rd,
                  tbl[i].st, tbl[i].fl, tbl[i].r1, tbl[i].r2);
            step();
            check("we3", i, 32'(wb.we3), 32'(tbl[i].ew));
            check("pc_src_w", i, 32'(wb.pc_src_w), 32'(tbl[i].ep));
            check("retire_cnt", i, 32'(wb.retire_cnt), 32'(tbl[i].er));
            if (tbl[i].cd) begin
                check("a3", i, 32'(wb.a3), 32'(tbl[i].ea));
                check("wd3", i, wb.wd3, tbl[i].ed);
                check("pc_target_w", i, wb.pc_target_w, tbl[i].ed);
            end
            check("rd1_d", i, wb.rd1_d, (BYP && tbl[i].ew && tbl[i].ea == tbl[i].r1) ? tbl[i].ed : 32'h55);
            check("rd2_d", i, wb.rd2_d, (BYP && tbl[i].ew && tbl[i].ea == tbl[i].r2) ? tbl[i].ed : 32'h66);
        end

        drive(1'b1, 1'b1, 1'b0, 4'd15, 32'h300, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        check("seq_pc_src", 0, 32'(wb.pc_src_w), 32'd1);
        check("seq_pc_target", 0, wb.pc_target_w, 32'h300);
        drive(1'b0, 1'b0, 1'b0, 4'd9, 32'h999, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        check("seq_shadow_a3", 0, 32'(wb.a3), 32'd9);
        check("seq_shadow_retire", 0, 32'(wb.retire_cnt), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a3", 0, 32'(wb.a3), 32'd0);
        check("async_rst_wd3", 0, wb.wd3, 32'd0);
        check("async_rst_retire", 0, 32'(wb.retire_cnt), 32'd0);
        check("async_rst_pc_src", 0, 32'(wb.pc_src_w), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h33, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        check("post_rst_we3", 0, 32'(wb.we3), 32'd1);
        check("post_rst_a3", 0, 32'(wb.a3), 32'd3);
        check("post_rst_wd3", 0, wb.wd3, 32'h33);
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h22, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        check("post_rst_we3", 1, 32'(wb.we3), 32'd1);
        check("post_rst_retire", 1, 32'(wb.retire_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);

        check("small_retire_start", 0, 32'(sm.retire_cnt), 32'd0);
        sm_valid = 1'b1;
        repeat (16) step();
        check("small_retire", 16, 32'(sm.retire_cnt), 32'd15);
        step();
        check("small_retire_wrap", 17, 32'(sm.retire_cnt), 32'd0);
        step();
        check("small_retire_after_wrap", 18, 32'(sm.retire_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
